uart_tx: RTL and testbench

- Serial UART transmitter; the transmit-side counterpart of the team's single-module UART receiver.
- Accepts a parallel byte through a start strobe and serialises it LSB-first onto a single line.
- Frame format: start bit 0, 8 data bits, optional parity bit, stop bit 1.
- Baud timing uses the same clocks-per-bit parameter as the receiver, so a TX→RX loopback works with matching parameters.

---
 rtl/uart_tx.sv | 151 +++++++++++++++
 tb/tb_uart_tx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter.
// Frame: start bit (0), 8 data bits LSB first, optional parity bit, stop bit (1).
// Each bit lasts CLKS_PER_BIT clock cycles.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   soft_rst     synchronous active-high reset
//   tx_start     level-sampled send request, honoured only when idle
//   tx_data_in   byte to send, captured on acceptance
//   tx_data_out  registered serial line, idles high
//   tx_busy      high while a frame is in progress
//   tx_done      one-cycle pulse after the stop bit completes
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 3,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       soft_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data_in,
  output logic       tx_data_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned     CW       = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic            ODD_INV  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic          bit_end;
  logic          line_d, busy_d, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    bit_end = (cnt_q == CNT_LAST);

    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          shreg_d = tx_data_in;
          par_d   = (^tx_data_in) ^ ODD_INV;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next-state values, so the line changes
    // on the same edge as the state and never sees tx_start combinationally.
    case (state_d)
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = shreg_d[idx_d];
      S_PARITY: line_d = par_d;
      default:  line_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_STOP) && (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      tx_data_out <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
    end else if (soft_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      tx_data_out <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      tx_data_out <= line_d;
      tx_busy     <= busy_d;
      tx_done     <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: drives three transmitters (no parity, even parity, odd parity)
// with shared stimulus and checks them against a frame-level model each cycle,
// plus directed frame decoding and hand-computed literal expectations.
module tb_uart_tx;

  localparam int C = 3;

  logic       clk;
  logic       rst;
  logic       soft_rst;
  logic       tx_start;
  logic [7:0] tx_data_in;
  logic       line0, line1, line2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;
  logic [2:0] lines, busys, dones;

  assign lines = {line2, line1, line0};
  assign busys = {busy2, busy1, busy0};
  assign dones = {done2, done1, done0};

  uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0)) u_dut (
    .clk(clk), .rst(rst), .soft_rst(soft_rst), .tx_start(tx_start),
    .tx_data_in(tx_data_in), .tx_data_out(line0), .tx_busy(busy0), .tx_done(done0));

  uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .clk(clk), .rst(rst), .soft_rst(soft_rst), .tx_start(tx_start),
    .tx_data_in(tx_data_in), .tx_data_out(line1), .tx_busy(busy1), .tx_done(done1));

  uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst(rst), .soft_rst(soft_rst), .tx_start(tx_start),
    .tx_data_in(tx_data_in), .tx_data_out(line2), .tx_busy(busy2), .tx_done(done2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame lengths in bits and busy durations in cycles (hand-computed for C=3).
  int flen[3]     = '{10, 11, 11};
  int busy_exp[3] = '{30, 33, 33};

  logic [79:0] line_h [3];
  logic [79:0] busy_h [3];
  logic [79:0] done_h [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] exp_frame(input int i, input logic [7:0] d);
    logic p;
    p = (i == 0) ? 1'b1 : ((i == 1) ? ^d : ~^d);
    return {1'b1, p, d, 1'b0};
  endfunction

  function automatic logic [10:0] fmask(input int i);
    return (flen[i] == 10) ? 11'h3FF : 11'h7FF;
  endfunction

  // Mid-bit sampling of a recorded line, frame beginning at cycle s.
  function automatic logic [10:0] decode(input int i, input int s);
    logic [10:0] r;
    int idx;
    r = '0;
    for (int b = 0; b < 11; b++) begin
      idx = s + b * C + C / 2;
      if (idx < 80) r[b] = line_h[i][idx];
    end
    return r & fmask(i);
  endfunction

  // Records outputs on ncyc consecutive falling edges, starting at the current one.
  task automatic rx_capture(input int ncyc);
    for (int i = 0; i < 3; i++) begin
      line_h[i] = '0;
      busy_h[i] = '0;
      done_h[i] = '0;
    end
    for (int n = 0; n < ncyc; n++) begin
      for (int i = 0; i < 3; i++) begin
        line_h[i][n] = lines[i];
        busy_h[i][n] = busys[i];
        done_h[i][n] = dones[i];
      end
      @(negedge clk);
    end
  endtask

  task automatic send_check(input logic [7:0] d, input string tag);
    tx_start   = 1'b1;
    tx_data_in = d;
    @(negedge clk);
    tx_start = 1'b0;
    rx_capture(38);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_frame%0d", tag, i), 32'(decode(i, 0)), 32'(exp_frame(i, d) & fmask(i)));
      chk($sformatf("%s_busylen%0d", tag, i), $countones(busy_h[i]), busy_exp[i]);
      chk($sformatf("%s_donecnt%0d", tag, i), $countones(done_h[i]), 1);
      chk($sformatf("%s_donepos%0d", tag, i), 32'(done_h[i][busy_exp[i]]), 1);
    end
  endtask

  // Frame-level model: after acceptance, cycle k of the frame shows bit k/C;
  // the cycle after the last bit carries the done pulse.
  task automatic model_checker();
    logic [10:0] fr [3];
    int          k [3];
    bit          act [3];
    bit          dn [3];
    logic        el;
    for (int i = 0; i < 3; i++) begin
      fr[i] = '1; k[i] = 0; act[i] = 1'b0; dn[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rst || soft_rst) begin
          act[i] = 1'b0;
          dn[i]  = 1'b0;
        end else if (act[i]) begin
          k[i]++;
          if (k[i] == flen[i] * C) begin
            act[i] = 1'b0;
            dn[i]  = 1'b1;
          end
        end else begin
          dn[i] = 1'b0;
          if (tx_start) begin
            act[i] = 1'b1;
            k[i]   = 0;
            fr[i]  = exp_frame(i, tx_data_in);
          end
        end
      end
      #1;
      for (int i = 0; i < 3; i++) begin
        el = act[i] ? fr[i][k[i] / C] : 1'b1;
        chk($sformatf("model_line%0d", i), 32'(lines[i]), 32'(el));
        chk($sformatf("model_busy%0d", i), 32'(busys[i]), 32'(act[i]));
        chk($sformatf("model_done%0d", i), 32'(dones[i]), 32'(dn[i]));
      end
    end
  endtask

  logic [10:0] fr_tmp;

  initial begin
    rst        = 1'b1;
    soft_rst   = 1'b0;
    tx_start   = 1'b0;
    tx_data_in = 8'h00;
    fork
      model_checker();
    join_none

    // Reset dominance: hard reset, then soft reset, with a pending request.
    repeat (2) @(negedge clk);
    tx_start   = 1'b1;
    tx_data_in = 8'hA5;
    for (int n = 0; n < 12 * C; n++) begin
      @(negedge clk);
      chk("rst_line", 32'(lines), 32'h7);
      chk("rst_busy", 32'(busys), 32'h0);
      chk("rst_done", 32'(dones), 32'h0);
    end
    rst      = 1'b0;
    soft_rst = 1'b1;
    for (int n = 0; n < 12 * C; n++) begin
      @(negedge clk);
      chk("srst_line", 32'(lines), 32'h7);
      chk("srst_busy", 32'(busys), 32'h0);
      chk("srst_done", 32'(dones), 32'h0);
    end
    soft_rst = 1'b0;
    tx_start = 1'b0;
    repeat (2) @(negedge clk);

    // Parity literals: 0x07 has odd weight, 0x03 even weight.
    send_check(8'h07, "par07");
    fr_tmp = decode(1, 0);
    chk("par07_even_bit", 32'(fr_tmp[9]), 1);
    fr_tmp = decode(2, 0);
    chk("par07_odd_bit", 32'(fr_tmp[9]), 0);
    send_check(8'h03, "par03");
    fr_tmp = decode(1, 0);
    chk("par03_even_bit", 32'(fr_tmp[9]), 0);
    fr_tmp = decode(2, 0);
    chk("par03_odd_bit", 32'(fr_tmp[9]), 1);

    // Exhaustive bytes.
    for (int v = 0; v < 256; v++) send_check(8'(v), "byte");

    // Busy protection: a request and data changes mid-frame are ignored.
    tx_start   = 1'b1;
    tx_data_in = 8'h3C;
    @(negedge clk);
    tx_start = 1'b0;
    fork
      rx_capture(70);
      begin
        repeat (4) @(negedge clk);
        tx_start   = 1'b1;
        tx_data_in = 8'hFF;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (5) @(negedge clk);
        tx_data_in = 8'h12;
      end
    join
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("busyprot_frame%0d", i), 32'(decode(i, 0)), 32'(exp_frame(i, 8'h3C) & fmask(i)));
      chk($sformatf("busyprot_busylen%0d", i), $countones(busy_h[i]), busy_exp[i]);
      chk($sformatf("busyprot_donecnt%0d", i), $countones(done_h[i]), 1);
    end

    // Back-to-back with tx_start held high; data changes during frame one.
    tx_start   = 1'b1;
    tx_data_in = 8'h55;
    @(negedge clk);
    fork
      rx_capture(75);
      begin
        repeat (5) @(negedge clk);
        tx_data_in = 8'hAA;
        repeat (35) @(negedge clk);
        tx_start = 1'b0;
      end
    join
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b_frame1_%0d", i), 32'(decode(i, 0)), 32'(exp_frame(i, 8'h55) & fmask(i)));
      chk($sformatf("b2b_frame2_%0d", i), 32'(decode(i, busy_exp[i] + 1)),
          32'(exp_frame(i, 8'hAA) & fmask(i)));
      chk($sformatf("b2b_done%0d", i), 32'(done_h[i][busy_exp[i]]), 1);
      chk($sformatf("b2b_gapbusy%0d", i), 32'(busy_h[i][busy_exp[i]]), 0);
      chk($sformatf("b2b_restart%0d", i), 32'(busy_h[i][busy_exp[i] + 1]), 1);
      chk($sformatf("b2b_startbit%0d", i), 32'(line_h[i][busy_exp[i] + 1]), 0);
      chk($sformatf("b2b_busylen%0d", i), $countones(busy_h[i]), 2 * busy_exp[i]);
      chk($sformatf("b2b_donecnt%0d", i), $countones(done_h[i]), 2);
    end
    repeat (4) @(negedge clk);

    // Soft abort during data bit 3 (0xF0 has bit 3 clear).
    tx_start   = 1'b1;
    tx_data_in = 8'hF0;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (13) @(negedge clk);
    chk("abort_pre_line", 32'(lines), 32'h0);
    soft_rst = 1'b1;
    @(negedge clk);
    soft_rst = 1'b0;
    chk("abort_line", 32'(lines), 32'h7);
    chk("abort_busy", 32'(busys), 32'h0);
    chk("abort_done", 32'(dones), 32'h0);
    rx_capture(40);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort_noresume%0d", i), $countones(busy_h[i]), 0);
      chk($sformatf("abort_nodone%0d", i), $countones(done_h[i]), 0);
    end
    send_check(8'h81, "post_abort");
    fr_tmp = decode(0, 0);
    chk("loopback_rx_data", 32'(fr_tmp[8:1]), 32'h81);
    chk("loopback_error", 32'((fr_tmp[0] != 1'b0) || (fr_tmp[9] != 1'b1)), 0);

    // Hard reset mid-frame releases the line without waiting for a clock edge.
    tx_start   = 1'b1;
    tx_data_in = 8'h00;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("arst_pre_line", 32'(lines), 32'h0);
    rst = 1'b1;
    #1;
    chk("arst_line", 32'(lines), 32'h7);
    chk("arst_busy", 32'(busys), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rx_capture(40);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("arst_noresume%0d", i), $countones(busy_h[i]), 0);
      chk($sformatf("arst_nodone%0d", i), $countones(done_h[i]), 0);
    end
    send_check(8'h5A, "recover");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
